ex_mem_stage: RTL and testbench

//  EX->MEM pipeline stage sitting directly downstream of the ALU.
//  - Registers the ALU result, the destination/memory control and the store data.
//  - Holds the architectural NZVC flags register.
//  - Evaluates the branch condition against the committed flags.
//  - Valid/ready handshake on both sides, with stall and flush.

---
 rtl/ex_mem_pkg.sv | 54 +++++
 rtl/ex_mem_stage_skid.sv | 64 ++++++
 rtl/ex_mem_stage.sv | 110 +++++++++++
 tb/tb_ex_mem_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM stage: condition codes, NZVC flags, payload struct
// and the branch-condition evaluator.
package ex_mem_pkg;

    localparam int EX_MEM_WIDTH      = 16;
    localparam int EX_MEM_REG_ADDR_W = 4;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } nzvc_t;

    // Field widths follow the package constants; the stage parameters must match them.
    typedef struct packed {
        logic [EX_MEM_WIDTH-1:0]      alu;
        logic [EX_MEM_REG_ADDR_W-1:0] rd_addr;
        logic                         wr_en;
        logic                         mem_rd;
        logic                         mem_wr;
        logic [EX_MEM_WIDTH-1:0]      store_data;
        logic                         br_taken;
    } ex_mem_payload_t;

    function automatic logic cond_eval(input cond_e cond, input nzvc_t f);
        logic r;
        case (cond)
            COND_EQ: r = f.z;
            COND_NE: r = ~f.z;
            COND_CS: r = f.c;
            COND_CC: r = ~f.c;
            COND_MI: r = f.n;
            COND_PL: r = ~f.n;
            COND_VS: r = f.v;
            COND_VC: r = ~f.v;
            COND_HI: r = f.c & ~f.z;
            COND_LS: r = ~f.c | f.z;
            COND_GE: r = (f.n == f.v);
            COND_LT: r = (f.n != f.v);
            COND_GT: r = ~f.z & (f.n == f.v);
            COND_LE: r = f.z | (f.n != f.v);
            COND_AL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_mem_stage_skid.sv
// Two-entry output buffer (output register + skid) for the EX->MEM stage.
// Only instantiated when EX_MEM_SKID_EN is defined; in_ready_o is fully registered.
module ex_mem_skid #(
    parameter int PW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          acc_i,
    input  logic [PW-1:0] data_i,
    input  logic          out_ready_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic [PW-1:0] data_o
);
    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] out_q, out_d;
    logic [PW-1:0] skid_q, skid_d;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (~out_valid_q | out_ready_i) begin
            // Older parked entry always moves ahead of a newly accepted one.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = acc_i;
                if (acc_i) skid_d = data_i;
            end else begin
                out_valid_d = acc_i;
                if (acc_i) out_d = data_i;
            end
        end else if (acc_i) begin
            skid_valid_d = 1'b1;
            skid_d       = data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign data_o      = out_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with NZVC flags and branch evaluation.
// Define EX_MEM_SKID_EN to add a one-entry skid buffer with registered in_ready.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int WIDTH      = EX_MEM_WIDTH,
    parameter int REG_ADDR_W = EX_MEM_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      alu_out,
    input  logic [3:0]            alu_nzvc,
    input  logic                  set_flags,
    input  logic                  is_branch,
    input  logic [3:0]            cond,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  wr_en,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [WIDTH-1:0]      store_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_alu,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_wr_en,
    output logic                  out_mem_rd,
    output logic                  out_mem_wr,
    output logic [WIDTH-1:0]      out_store_data,
    output logic                  out_br_taken,
    output logic [3:0]            flags_q
);
    logic            acc;
    logic [3:0]      flags_d;
    ex_mem_payload_t pl_in, pl_out;

    assign acc = in_valid & in_ready & ~flush;

    // Branch sees the committed flags, never the ones this instruction produces.
    assign pl_in = '{alu:        alu_out,
                     rd_addr:    rd_addr,
                     wr_en:      wr_en,
                     mem_rd:     mem_rd,
                     mem_wr:     mem_wr,
                     store_data: store_data,
                     br_taken:   is_branch & cond_eval(cond_e'(cond), nzvc_t'(flags_q))};

    assign flags_d = (acc & set_flags) ? alu_nzvc : flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flags_q <= '0;
        else     flags_q <= flags_d;
    end

`ifdef EX_MEM_SKID_EN
    ex_mem_skid #(.PW($bits(ex_mem_payload_t))) u_skid (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .acc_i       (acc),
        .data_i      (pl_in),
        .out_ready_i (out_ready),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .data_o      (pl_out)
    );
`else
    logic            out_valid_q, out_valid_d;
    ex_mem_payload_t pl_q, pl_d;

    assign in_ready = ~out_valid_q | out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        pl_d        = pl_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (acc) begin
            out_valid_d = 1'b1;
            pl_d        = pl_in;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pl_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            pl_q        <= pl_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pl_out    = pl_q;
`endif

    assign out_alu        = pl_out.alu;
    assign out_rd_addr    = pl_out.rd_addr;
    assign out_wr_en      = pl_out.wr_en;
    assign out_mem_rd     = pl_out.mem_rd;
    assign out_mem_wr     = pl_out.mem_wr;
    assign out_store_data = pl_out.store_data;
    assign out_br_taken   = pl_out.br_taken;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: scoreboard of accepted payloads plus
// per-scenario tasks. Builds for both EX_MEM_SKID_EN settings.
module tb_ex_mem_stage;
    import ex_mem_pkg::*;

`ifdef EX_MEM_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] alu_out, store_data;
    logic [3:0]  alu_nzvc, cond, rd_addr;
    logic        set_flags, is_branch, wr_en, mem_rd, mem_wr, flush;
    logic        out_valid, out_ready;
    logic [15:0] out_alu, out_store_data;
    logic [3:0]  out_rd_addr, flags_q;
    logic        out_wr_en, out_mem_rd, out_mem_wr, out_br_taken;

    int n_checks = 0;
    int n_pass   = 0;

    ex_mem_payload_t sb[$];
    logic [3:0]      m_flags;
    logic            m_ready;
    ex_mem_payload_t m_pop, m_push;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_nzvc(alu_nzvc), .set_flags(set_flags),
        .is_branch(is_branch), .cond(cond), .rd_addr(rd_addr), .wr_en(wr_en),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .store_data(store_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu(out_alu),
        .out_rd_addr(out_rd_addr), .out_wr_en(out_wr_en), .out_mem_rd(out_mem_rd),
        .out_mem_wr(out_mem_wr), .out_store_data(out_store_data),
        .out_br_taken(out_br_taken), .flags_q(flags_q)
    );

    // Reference condition table; f = {N,Z,V,C}.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        {n, z, v, cy} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor/scoreboard: samples 1 time unit before each rising edge.
    always @(negedge clk) begin
        #4;
        if (!rst) begin
            m_ready = (DEPTH == 2) ? (sb.size() < 2) : (sb.size() == 0 || out_ready);
            n_checks++;
            if (in_ready !== m_ready) $display("FAIL in_ready got=%b exp=%b t=%0t", in_ready, m_ready, $time);
            else n_pass++;
            n_checks++;
            if (out_valid !== (sb.size() > 0)) $display("FAIL out_valid got=%b exp=%b t=%0t", out_valid, sb.size() > 0, $time);
            else n_pass++;
            if (sb.size() > 0 && out_ready && !flush) begin
                m_pop = sb.pop_front();
                n_checks++;
                if ({out_alu, out_rd_addr, out_wr_en, out_mem_rd, out_mem_wr, out_store_data, out_br_taken} !== m_pop)
                    $display("FAIL payload got=%h exp=%h t=%0t",
                             {out_alu, out_rd_addr, out_wr_en, out_mem_rd, out_mem_wr, out_store_data, out_br_taken},
                             m_pop, $time);
                else n_pass++;
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && m_ready) begin
                m_push = '{alu: alu_out, rd_addr: rd_addr, wr_en: wr_en, mem_rd: mem_rd, mem_wr: mem_wr,
                           store_data: store_data, br_taken: is_branch && ref_cond(cond, m_flags)};
                sb.push_back(m_push);
                if (set_flags) m_flags = alu_nzvc;
            end
        end
    end

    task automatic set_in(input logic v, input logic [15:0] a, input logic [3:0] nz,
                          input logic sf, input logic br, input logic [3:0] c);
        in_valid   = v;
        alu_out    = a;
        alu_nzvc   = nz;
        set_flags  = sf;
        is_branch  = br;
        cond       = c;
        rd_addr    = 4'($urandom);
        wr_en      = 1'($urandom);
        mem_rd     = 1'($urandom);
        mem_wr     = 1'($urandom);
        store_data = 16'($urandom);
    endtask

    task automatic idle();
        set_in(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        sb.delete();
        m_flags = 4'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        set_in(1'b1, 16'h1111, 4'b1010, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        out_ready = 1'b0;
        set_in(1'b1, 16'h2222, 4'b0000, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        n_checks++;
        if (flags_q !== 4'b1010) $display("FAIL pre_reset_flags got=%b exp=1010", flags_q);
        else n_pass++;
        // Assert reset mid-cycle, with the payload stalled, and look before any edge.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        else n_pass++;
        n_checks++;
        if (flags_q !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", flags_q);
        else n_pass++;
        n_checks++;
        if ({out_alu, out_rd_addr, out_wr_en, out_mem_rd, out_mem_wr, out_store_data, out_br_taken} !== 40'h0)
            $display("FAIL reset_payload got=%h exp=0", {out_alu, out_store_data});
        else n_pass++;
        sb.delete();
        m_flags = 4'h0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_flags_branch();
        out_ready = 1'b1;
        set_in(1'b1, 16'h0A0A, 4'b0100, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        set_in(1'b1, 16'h0B0B, 4'b0000, 1'b0, 1'b1, COND_EQ);
        @(negedge clk);
        n_checks++;
        if (flags_q !== 4'b0100) $display("FAIL flags_after_set got=%b exp=0100", flags_q);
        else n_pass++;
        n_checks++;
        if (out_br_taken !== 1'b1) $display("FAIL branch_eq got=%b exp=1", out_br_taken);
        else n_pass++;
        set_in(1'b1, 16'h0C0C, 4'b0000, 1'b0, 1'b1, COND_NE);
        @(negedge clk);
        n_checks++;
        if (out_br_taken !== 1'b0) $display("FAIL branch_ne got=%b exp=0", out_br_taken);
        else n_pass++;
        idle();
        @(negedge clk);
    endtask

    task automatic test_same_instr();
        do_reset();
        out_ready = 1'b1;
        set_in(1'b1, 16'h0D0D, 4'b0100, 1'b1, 1'b1, COND_EQ);
        @(negedge clk);
        n_checks++;
        if (out_br_taken !== 1'b0) $display("FAIL same_instr_branch got=%b exp=0", out_br_taken);
        else n_pass++;
        n_checks++;
        if (flags_q !== 4'b0100) $display("FAIL same_instr_flags got=%b exp=0100", flags_q);
        else n_pass++;
        idle();
        @(negedge clk);
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        set_in(1'b1, 16'h1234, 4'h0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        out_ready = 1'b0;
        set_in(1'b1, 16'h5678, 4'h0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_alu !== 16'h1234)
                $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/1234", i, out_valid, out_alu);
            else n_pass++;
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready);
            else n_pass++;
            set_in(1'b1, 16'h9ABC, 4'h0, 1'b0, 1'b0, 4'h0);
        end
        out_ready = 1'b1;
        idle();
        @(negedge clk);
`ifdef EX_MEM_SKID_EN
        n_checks++;
        if (out_valid !== 1'b1 || out_alu !== 16'h5678)
            $display("FAIL skid_drain got=%b/%h exp=1/5678", out_valid, out_alu);
        else n_pass++;
        @(negedge clk);
`endif
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL stall_drained got=%b exp=0", out_valid);
        else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        set_in(1'b1, 16'h4321, 4'b0011, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        out_ready = 1'b0;
        set_in(1'b1, 16'h8765, 4'b0000, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        flush = 1'b1;
        set_in(1'b1, 16'hDEAD, 4'b1000, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        flush = 1'b0;
        idle();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", out_valid);
        else n_pass++;
        n_checks++;
        if (flags_q !== 4'b0011) $display("FAIL flush_flags got=%b exp=0011", flags_q);
        else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_no_drain got=%b exp=0", out_valid);
        else n_pass++;
    endtask

    task automatic test_cond_sweep();
        out_ready = 1'b1;
        for (int f = 0; f < 16; f++) begin
            set_in(1'b1, 16'hF000, 4'(f), 1'b1, 1'b0, 4'h0);
            @(negedge clk);
            for (int c = 0; c < 16; c++) begin
                set_in(1'b1, 16'(c), 4'h0, 1'b0, 1'b1, 4'(c));
                @(negedge clk);
                n_checks++;
                if (out_br_taken !== ref_cond(4'(c), 4'(f)))
                    $display("FAIL cond_sweep c=%0d f=%b got=%b exp=%b", c, 4'(f), out_br_taken, ref_cond(4'(c), 4'(f)));
                else n_pass++;
            end
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            set_in(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
            @(negedge clk);
        end
        out_ready = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) $display("FAIL b2b_drain left=%0d exp=0", sb.size());
        else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        m_flags   = 4'h0;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || flags_q !== 4'h0) $display("FAIL initial_reset got=%b/%b exp=0/0000", out_valid, flags_q);
        else n_pass++;
        test_reset();
        test_flags_branch();
        test_same_instr();
        test_stall();
        test_flush();
        test_cond_sweep();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
